// File: rtl/maze_pkg.sv
// Shared encodings for the 5x5 maze step controller: actions, FSM states,
// episode-end reasons and grid constants.
package maze_pkg;

  localparam int STATE_W         = 6;
  localparam int MAZE_GRID_W     = 5;
  localparam int MAZE_GOAL_STATE = 25;

  typedef enum logic [1:0] {
    ACT_UP    = 2'd0,
    ACT_DOWN  = 2'd1,
    ACT_LEFT  = 2'd2,
    ACT_RIGHT = 2'd3
  } maze_act_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACT = 2'd1,
    ST_EVAL     = 2'd2,
    ST_RESULT   = 2'd3
  } maze_state_e;

  typedef enum logic [1:0] {
    DR_NONE    = 2'd0,
    DR_GOAL    = 2'd1,
    DR_HAZARD  = 2'd2,
    DR_TIMEOUT = 2'd3
  } maze_done_e;

endpackage

// File: rtl/maze_move_calc.sv
// Combinational move: (cur_state, action) -> destination, with any move that
// would leave the grid clamped to cur_state.
module maze_move_calc
  import maze_pkg::*;
#(
  parameter int GRID_W = MAZE_GRID_W
) (
  input  logic [STATE_W-1:0] cur_state,
  input  logic [1:0]         action,
  output logic [STATE_W-1:0] nxt_state
);

  logic [STATE_W-1:0] idx;
  logic [STATE_W-1:0] row;
  logic [STATE_W-1:0] col;

  assign idx = cur_state - STATE_W'(1);

  // Constant compare chain replaces the divide by GRID_W.
  always_comb begin
    row = '0;
    for (int r = 1; r < GRID_W; r++) begin
      if (idx >= STATE_W'(r * GRID_W)) row = STATE_W'(r);
    end
    col = idx - STATE_W'(32'(row) * GRID_W);
  end

  always_comb begin
    nxt_state = cur_state;
    case (action)
      ACT_UP:    if (row != '0)                    nxt_state = cur_state - STATE_W'(GRID_W);
      ACT_DOWN:  if (row != STATE_W'(GRID_W - 1))  nxt_state = cur_state + STATE_W'(GRID_W);
      ACT_LEFT:  if (col != '0)                    nxt_state = cur_state - STATE_W'(1);
      ACT_RIGHT: if (col != STATE_W'(GRID_W - 1))  nxt_state = cur_state + STATE_W'(1);
      default:   nxt_state = cur_state;
    endcase
  end

endmodule

// File: rtl/maze_step_controller.sv
// One Q-learning episode on the maze: accepts an action, resolves the clamped
// destination, samples the external reward generator and returns the result.
module maze_step_controller
  import maze_pkg::*;
#(
  parameter int GRID_W      = MAZE_GRID_W,
  parameter int START_STATE = 1,
  parameter int GOAL_STATE  = MAZE_GOAL_STATE,
  parameter int MAX_STEPS   = 64,
  parameter int CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      action_valid,
  input  logic [1:0]                action,
  output logic                      action_ready,
  output logic [STATE_W-1:0]        query_state,
  input  logic signed [15:0]        query_reward,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic [STATE_W-1:0]        cur_state,
  output logic [STATE_W-1:0]        next_state,
  output logic signed [15:0]        reward,
  output logic                      terminal,
  output logic [1:0]                done_reason,
  output logic                      busy,
  output logic [CNT_W-1:0]          episode_cnt
);

  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  localparam logic [STEP_W-1:0] LAST_CNT = STEP_W'(MAX_STEPS - 1);

  maze_state_e        state, state_nxt;
  logic [STEP_W-1:0]  step_cnt;
  logic [STATE_W-1:0] move_nxt;
  logic               is_goal, is_hazard, is_timeout;

  maze_move_calc #(.GRID_W(GRID_W)) u_move (
    .cur_state (cur_state),
    .action    (action),
    .nxt_state (move_nxt)
  );

  // Reward generator always sees the registered destination, so its input
  // never glitches while the result is being held.
  assign query_state = next_state;

  assign is_goal    = (next_state == STATE_W'(GOAL_STATE));
  assign is_hazard  = (query_reward < 16'sd0);
  assign is_timeout = (step_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (start)        state_nxt = ST_WAIT_ACT;
      ST_WAIT_ACT: if (action_valid) state_nxt = ST_EVAL;
      ST_EVAL:                       state_nxt = ST_RESULT;
      ST_RESULT:   if (result_ready) state_nxt = terminal ? ST_IDLE : ST_WAIT_ACT;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    action_ready = (state == ST_WAIT_ACT);
    result_valid = (state == ST_RESULT);
    busy         = (state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state   <= STATE_W'(START_STATE);
      next_state  <= '0;
      reward      <= '0;
      terminal    <= 1'b0;
      done_reason <= DR_NONE;
      step_cnt    <= '0;
      episode_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          cur_state <= STATE_W'(START_STATE);
          step_cnt  <= '0;
        end
        ST_WAIT_ACT: if (action_valid) next_state <= move_nxt;
        ST_EVAL: begin
          reward   <= query_reward;
          terminal <= is_goal | is_hazard | is_timeout;
          if      (is_goal)    done_reason <= DR_GOAL;
          else if (is_hazard)  done_reason <= DR_HAZARD;
          else if (is_timeout) done_reason <= DR_TIMEOUT;
          else                 done_reason <= DR_NONE;
        end
        ST_RESULT: if (result_ready) begin
          cur_state <= next_state;
          step_cnt  <= step_cnt + 1'b1;
          if (terminal && (episode_cnt != '1)) episode_cnt <= episode_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_step_controller.sv
// Directed bench: default maze instance plus a MAX_STEPS=4 instance for timeout.
module tb_maze_step_controller;
  import maze_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic action_valid = 1'b0;
  logic [1:0] action = 2'd0;
  logic result_ready = 1'b0;
  logic sel = 1'b0;

  logic ar_a, rv_a, term_a, busy_a, ar_b, rv_b, term_b, busy_b;
  logic [5:0] qs_a, cs_a, ns_a, qs_b, cs_b, ns_b;
  logic signed [15:0] qr_a, rw_a, qr_b, rw_b;
  logic [1:0] dr_a, dr_b;
  logic [15:0] ec_a, ec_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Reward generator model: goal pays 100, states 3 and 22 are hazards.
  function automatic logic signed [15:0] rwd(input logic [5:0] s);
    if (s == 6'd25)                return 16'sd100;
    if (s == 6'd3 || s == 6'd22)   return -16'sd46;
    return 16'sd0;
  endfunction

  assign qr_a = rwd(qs_a);
  assign qr_b = rwd(qs_b);

  maze_step_controller u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .action_valid(action_valid),
    .action(action), .action_ready(ar_a), .query_state(qs_a), .query_reward(qr_a),
    .result_valid(rv_a), .result_ready(result_ready), .cur_state(cs_a),
    .next_state(ns_a), .reward(rw_a), .terminal(term_a), .done_reason(dr_a),
    .busy(busy_a), .episode_cnt(ec_a)
  );

  maze_step_controller #(.MAX_STEPS(4)) u_to (
    .clk(clk), .rst_n(rst_n), .start(start_b), .action_valid(action_valid),
    .action(action), .action_ready(ar_b), .query_state(qs_b), .query_reward(qr_b),
    .result_valid(rv_b), .result_ready(result_ready), .cur_state(cs_b),
    .next_state(ns_b), .reward(rw_b), .terminal(term_b), .done_reason(dr_b),
    .busy(busy_b), .episode_cnt(ec_b)
  );

  logic o_ar, o_rv, o_term, o_busy;
  logic [5:0] o_cs, o_ns;
  logic [15:0] o_rw, o_ec;
  logic [1:0] o_dr;
  assign o_ar   = sel ? ar_b   : ar_a;
  assign o_rv   = sel ? rv_b   : rv_a;
  assign o_term = sel ? term_b : term_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_cs   = sel ? cs_b   : cs_a;
  assign o_ns   = sel ? ns_b   : ns_a;
  assign o_rw   = sel ? rw_b   : rw_a;
  assign o_ec   = sel ? ec_b   : ec_a;
  assign o_dr   = sel ? dr_b   : dr_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_ep(input logic which);
    @(negedge clk);
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic step(input string tag, input logic [1:0] a, input logic [5:0] en,
                      input logic [15:0] er, input logic et, input logic [1:0] ed);
    int n = 0;
    @(negedge clk);
    while (!o_ar && n < 10) begin @(negedge clk); n++; end
    chk({tag, "_ardy"}, 32'(o_ar), 32'd1);
    action = a; action_valid = 1'b1;
    @(posedge clk); #1;
    action_valid = 1'b0;
    chk({tag, "_rv_n1"}, 32'(o_rv), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_rv_n2"}, 32'(o_rv), 32'd1);
    chk({tag, "_next"},  32'(o_ns), 32'(en));
    chk({tag, "_rew"},   32'(o_rw), 32'(er));
    chk({tag, "_term"},  32'(o_term), 32'(et));
    chk({tag, "_why"},   32'(o_dr), 32'(ed));
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    chk({tag, "_cur"}, 32'(o_cs), 32'(en));
  endtask

  initial begin
    #12;
    chk("rst_cur",  32'(o_cs), 32'd1);
    chk("rst_next", 32'(o_ns), 32'd0);
    chk("rst_rew",  32'(o_rw), 32'd0);
    chk("rst_rv",   32'(o_rv), 32'd0);
    chk("rst_ar",   32'(o_ar), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_ec",   32'(o_ec), 32'd0);
    chk("rst_term", 32'(o_term), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Step into state 2, then into the hazard at 3.
    start_ep(1'b0);
    chk("st_busy", 32'(o_busy), 32'd1);
    step("s1r", ACT_RIGHT, 6'd2, 16'h0000, 1'b0, DR_NONE);
    step("s2r", ACT_RIGHT, 6'd3, 16'hFFD2, 1'b1, DR_HAZARD);
    chk("hz_busy", 32'(o_busy), 32'd0);
    chk("hz_ar",   32'(o_ar), 32'd0);
    chk("hz_ec",   32'(o_ec), 32'd1);

    // Wall clamps, then a route around the hazard at 22 to the goal.
    start_ep(1'b0);
    step("wup", ACT_UP,   6'd1, 16'h0000, 1'b0, DR_NONE);
    step("wlf", ACT_LEFT, 6'd1, 16'h0000, 1'b0, DR_NONE);
    chk("wall_steps", 32'(u_dut.step_cnt), 32'd2);
    step("d6",  ACT_DOWN,  6'd6,  16'h0000, 1'b0, DR_NONE);
    step("d11", ACT_DOWN,  6'd11, 16'h0000, 1'b0, DR_NONE);
    step("d16", ACT_DOWN,  6'd16, 16'h0000, 1'b0, DR_NONE);
    step("d21", ACT_DOWN,  6'd21, 16'h0000, 1'b0, DR_NONE);
    step("wdn", ACT_DOWN,  6'd21, 16'h0000, 1'b0, DR_NONE);
    step("u16", ACT_UP,    6'd16, 16'h0000, 1'b0, DR_NONE);
    step("r17", ACT_RIGHT, 6'd17, 16'h0000, 1'b0, DR_NONE);
    step("r18", ACT_RIGHT, 6'd18, 16'h0000, 1'b0, DR_NONE);
    step("r19", ACT_RIGHT, 6'd19, 16'h0000, 1'b0, DR_NONE);
    step("r20", ACT_RIGHT, 6'd20, 16'h0000, 1'b0, DR_NONE);
    step("wrt", ACT_RIGHT, 6'd20, 16'h0000, 1'b0, DR_NONE);
    step("l19", ACT_LEFT,  6'd19, 16'h0000, 1'b0, DR_NONE);
    step("d24", ACT_DOWN,  6'd24, 16'h0000, 1'b0, DR_NONE);
    step("r25", ACT_RIGHT, 6'd25, 16'd100,  1'b1, DR_GOAL);
    chk("goal_ec",   32'(o_ec), 32'd2);
    chk("goal_busy", 32'(o_busy), 32'd0);

    // Back-pressure: result held five cycles while a stray action is offered.
    start_ep(1'b0);
    @(negedge clk);
    action = ACT_DOWN; action_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_rv",   32'(o_rv), 32'd1);
      chk("hold_ar",   32'(o_ar), 32'd0);
      chk("hold_next", 32'(o_ns), 32'd6);
      chk("hold_cur",  32'(o_cs), 32'd1);
      @(posedge clk); #1;
    end
    action_valid = 1'b0;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    chk("hold_cur_after", 32'(o_cs), 32'd6);

    // Reset while in EVAL: everything returns to reset values at once.
    @(negedge clk);
    action = ACT_DOWN; action_valid = 1'b1;
    @(posedge clk); #1;
    action_valid = 1'b0;
    chk("pre_rst_next", 32'(o_ns), 32'd11);
    rst_n = 1'b0;
    #1;
    chk("mrst_cur",  32'(o_cs), 32'd1);
    chk("mrst_next", 32'(o_ns), 32'd0);
    chk("mrst_busy", 32'(o_busy), 32'd0);
    chk("mrst_rv",   32'(o_rv), 32'd0);
    chk("mrst_ec",   32'(o_ec), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Timeout instance: four clamped moves, the fourth ends the episode.
    sel = 1'b1;
    start_ep(1'b1);
    step("to1", ACT_UP, 6'd1, 16'h0000, 1'b0, DR_NONE);
    step("to2", ACT_UP, 6'd1, 16'h0000, 1'b0, DR_NONE);
    step("to3", ACT_UP, 6'd1, 16'h0000, 1'b0, DR_NONE);
    step("to4", ACT_UP, 6'd1, 16'h0000, 1'b1, DR_TIMEOUT);
    chk("to_ec",   32'(o_ec), 32'd1);
    chk("to_busy", 32'(o_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/maze_step_controller.md
Name: maze_step_controller

Overview:
- Sequences one Q-learning agent episode on the 5x5 maze.
- Holds the agent's current state and accepts one action per step over a valid/ready handshake.
- Computes the wall-clamped next state, queries the combinational reward generator, and returns (next_state, reward, terminal) over a second valid/ready handshake.
- Ends the episode on goal, hazard or step timeout. Sits between the agent/Q-table update engine and the reward generator.

Parameters:
- GRID_W, 5, maze width and height; states numbered 1..GRID_W*GRID_W, row-major, state = row*GRID_W + col + 1.
- START_STATE, 1, state loaded at episode start.
- GOAL_STATE, 25, terminal success state.
- MAX_STEPS, 64, step limit per episode; timeout when reached.
- CNT_W, 16, width of the episode counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin episode; sampled only in IDLE.
- action_valid  in  1  action offered.
- action  in  2  0=up(row-1), 1=down(row+1), 2=left(col-1), 3=right(col+1).
- action_ready  out  1  high only in WAIT_ACT.
- query_state  out  6  to reward generator next_state input.
- query_reward  in  16 signed  from reward generator next_reward output.
- result_valid  out  1  step result available.
- result_ready  in  1  consumer accepts result.
- cur_state  out  6  agent state before the step.
- next_state  out  6  registered step destination.
- reward  out  16 signed  registered reward for next_state.
- terminal  out  1  this step ends the episode.
- done_reason  out  2  0=none, 1=goal, 2=hazard, 3=timeout; valid with result_valid.
- busy  out  1  high in any state except IDLE.
- episode_cnt  out  CNT_W  completed episodes; saturates at all-ones.

Behaviour:
- Reset (async, rst_n low): FSM=IDLE, cur_state=START_STATE, next_state=0, reward=0, step_cnt=0, episode_cnt=0, all valid/ready/terminal=0, done_reason=0. Mid-step reset abandons the step with no result.
- FSM states and transitions:
  - IDLE: start=1 -> load cur_state=START_STATE, step_cnt=0 -> WAIT_ACT.
  - WAIT_ACT: action_ready=1; on action_valid: compute the destination (move off-grid leaves the state unchanged), register it in next_state -> EVAL.
  - EVAL: query_state=next_state; register reward<=query_reward; compute terminal and done_reason -> RESULT.
  - RESULT: result_valid=1. All result outputs are held stable until result_ready. On handshake: cur_state<=next_state, step_cnt<=step_cnt+1. If terminal: episode_cnt++ -> IDLE; else -> WAIT_ACT.
- Latency: action accepted in cycle N -> result_valid asserted in cycle N+2. Minimum step period is 3 cycles with result_ready tied high.
- Terminal priority: goal (next_state==GOAL_STATE) > hazard (query_reward < 0, signed) > timeout (step_cnt+1 == MAX_STEPS) > none.
- query_state is driven with next_state in every state, so the reward generator sees a stable input.
- start is ignored outside IDLE. action_valid is ignored outside WAIT_ACT.
- Simultaneous result_ready and start in RESULT: start is ignored; the FSM enters IDLE and needs a new start.
- Wall clamp: up at row 0, down at row GRID_W-1, left at col 0 and right at col GRID_W-1 all give next_state=cur_state. The clamped step still counts toward MAX_STEPS.
- Width rules:
  - step_cnt is $clog2(MAX_STEPS+1) bits.
  - Row and column are derived from cur_state-1 using a constant divide by GRID_W (ROM or compare chain, no runtime divider).
  - episode_cnt saturates at all-ones.

Decomposition:
- Shared package maze_pkg:
  - action encodings ACT_UP/DOWN/LEFT/RIGHT.
  - FSM state enum (IDLE, WAIT_ACT, EVAL, RESULT).
  - done_reason encodings.
  - GRID_W, GOAL_STATE, state width constant 6.
- One sub-module, maze_move_calc: combinational (cur_state, action) -> clamped next state, parameterised by GRID_W.

Test Plan:
- Reset, start, action=3 from state 1 -> next_state=2, reward=0, terminal=0, result_valid two cycles after accept.
- From state 2, action=3 -> next_state=3, reward=16'hFFD2, terminal=1, done_reason=2; FSM returns to IDLE and episode_cnt=1.
- From state 1, action=0 then action=2 -> next_state=1 both times (wall clamp), reward=0, step_cnt=2.
- Path 1->6->11->16->21 (down), then 22 avoided via 16->... reaching 24 then right -> next_state=25, reward=100, done_reason=1.
- MAX_STEPS=4 with four clamped up moves from state 1 -> 4th result terminal=1, done_reason=3.
- Hold result_ready=0 for 5 cycles in RESULT -> outputs stable, action_ready=0. Assert rst_n low mid-EVAL -> all outputs return to reset values immediately.
